aes_round_seq: RTL and testbench
================================

Name: aes_round_seq

Overview:
- Iterative AES encryption round sequencer: one round per clock through a single round datapath (sub_bytes -> shift_rows -> mix_columns -> add-round-key), 128-bit state register.
- Accepts a plaintext block on a valid/ready input, fetches round keys from an external key-schedule store by index, and presents the ciphertext on a valid/ready output.
- Sits between the block-cipher front end (mode/FIFO logic) and the key-expansion RAM. Instantiates the existing sub_bytes, shift_rows and mix_columns blocks.

Parameters:
- NR, 10, number of rounds. Legal values are 10, 12 and 14 (AES-128/192/256).
- RW, 4, width of the round index bus. Must satisfy 2^RW > NR.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  plaintext offered
- in_ready  output  1  sequencer can accept plaintext
- in_data  input  128  plaintext, byte 0 in [127:120], column-major
- rk_idx  output  RW  index of the round key needed this cycle
- rk_data  input  128  round key for rk_idx, valid combinationally in the same cycle
- out_valid  output  1  ciphertext held on out_data
- out_ready  input  1  consumer accepts ciphertext
- out_data  output  128  ciphertext, same byte order as in_data
- busy  output  1  high in ROUND or DONE

Behaviour:
- States are IDLE, ROUND and DONE. Round counter rnd is RW bits wide.
- Reset (rst_n=0 at an edge): state=IDLE, rnd=0, state register=0, out_valid=0, busy=0. Reset is honoured mid-operation; the block in flight is discarded and no partial output appears.
- in_ready=1 only in IDLE (combinational from state). out_valid=1 only in DONE. out_data is driven directly from the state register.
- rk_idx = rnd in ROUND. rk_idx = 0 in IDLE, so key 0 is presented while waiting.
- IDLE: on an edge with in_valid & in_ready, state register <= in_data ^ rk_data (round 0); rnd <= 1; go to ROUND.
- ROUND, rnd < NR: state register <= mix_columns(shift_rows(sub_bytes(s))) ^ rk_data; rnd <= rnd+1.
- ROUND, rnd == NR: state register <= shift_rows(sub_bytes(s)) ^ rk_data, with no mix_columns; go to DONE.
- Latency: out_valid rises after edge NR+1, counting the accept edge as edge 1. For NR=10 that is 11 edges from acceptance to out_valid.
- DONE: out_data is held stable while out_valid=1 & out_ready=0, with no limit on stall length. On an edge with out_ready=1: go to IDLE, rnd <= 0. The state register keeps its value.
- Throughput is one block per NR+2 cycles minimum. There is no overlap: in_ready stays 0 in the cycle in which DONE completes, even if in_valid=1.
- in_valid or in_data changing while the block is not in IDLE is ignored.
- rk_data must not be used as a registered input. The key for index rnd is consumed at the same edge at which rnd is presented.
- rnd never exceeds NR. There is no wrap-around path.

Test Plan:
- FIPS-197 C.1 (NR=10): key schedule model for key 000102030405060708090a0b0c0d0e0f, in_data=00112233445566778899aabbccddeeff -> out_data=69c4e0d86a7b0430d8cdb78070b4c55a; out_valid rises 11 edges after acceptance; rk_idx steps 1..10 during ROUND.
- Back-pressure: hold out_ready=0 for 20 cycles in DONE -> out_valid stays 1, out_data unchanged, in_ready=0. Then out_ready=1 for one edge -> IDLE, in_ready=1 next cycle.
- Back-to-back: in_valid held high with two plaintexts (second 00000000000000000000000000000000) and out_ready tied 1 -> second block accepted exactly 1 cycle after the first out_valid cycle; both ciphertexts match the model; start interval is 12 cycles.
- Reset mid-round: assert rst_n=0 for one edge when rnd=5 -> next cycle state IDLE, out_valid=0, busy=0, in_ready=1. A fresh C.1 run then produces the correct ciphertext.
- Input ignored while busy: toggle in_valid and in_data during ROUND -> no effect on result and in_ready stays 0.
- NR=14 build: FIPS-197 C.3 key 000102...1e1f, same plaintext -> 8ea2b7ca516745bfeafc49904b496089; rk_idx reaches 14; latency is 15 edges.

Source files
------------

// File: rtl/aes_round_seq.sv
// Iterative AES-128/192/256 encryption core: one round per clock through a single
// round datapath, round keys fetched combinationally from an external key store.

module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  // Forward S-box, entry 0 in the top byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  assign y = SBOX[{~a, 3'b000} +: 8];
endmodule

module sub_bytes (
  input  logic [127:0] in_s,
  output logic [127:0] out_s
);
  for (genvar i = 0; i < 16; i++) begin : g_sb
    aes_sbox u_sbox (.a(in_s[8*i +: 8]), .y(out_s[8*i +: 8]));
  end
endmodule

module shift_rows (
  input  logic [127:0] in_s,
  output logic [127:0] out_s
);
  // Byte (row r, col c) sits at index 4c+r, counted from the top byte.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign out_s[127-8*(4*c+r) -: 8] = in_s[127-8*(4*((c+r)%4)+r) -: 8];
    end
  end
endmodule

module aes_mix_col (
  input  logic [31:0] col_i,
  output logic [31:0] col_o
);
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [7:0] a0, a1, a2, a3;
  assign {a0, a1, a2, a3} = col_i;
  assign col_o = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                  a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                  a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                  xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
endmodule

module mix_columns (
  input  logic [127:0] in_s,
  output logic [127:0] out_s
);
  for (genvar c = 0; c < 4; c++) begin : g_mc
    aes_mix_col u_col (.col_i(in_s[127-32*c -: 32]), .col_o(out_s[127-32*c -: 32]));
  end
endmodule

module aes_round_seq #(
  parameter int NR = 10,  // 10, 12 or 14
  parameter int RW = 4    // 2**RW > NR
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [127:0]  in_data,
  output logic [RW-1:0] rk_idx,
  input  logic [127:0]  rk_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [127:0]  out_data,
  output logic          busy
);
  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_e;

  localparam logic [RW-1:0] LAST = RW'(NR);

  state_e        state_q, state_d;
  logic [RW-1:0] rnd_q, rnd_d;
  logic [127:0]  st_q, st_d;
  logic [127:0]  sb_s, sr_s, mc_s;

  sub_bytes   u_sb (.in_s(st_q), .out_s(sb_s));
  shift_rows  u_sr (.in_s(sb_s), .out_s(sr_s));
  mix_columns u_mc (.in_s(sr_s), .out_s(mc_s));

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    st_d    = st_q;
    case (state_q)
      IDLE: if (in_valid) begin
        st_d    = in_data ^ rk_data;
        rnd_d   = RW'(1);
        state_d = ROUND;
      end
      ROUND: if (rnd_q == LAST) begin
        // final round skips mix_columns; rnd parks at NR until DONE drains
        st_d    = sr_s ^ rk_data;
        state_d = DONE;
      end else begin
        st_d  = mc_s ^ rk_data;
        rnd_d = rnd_q + RW'(1);
      end
      DONE: if (out_ready) begin
        state_d = IDLE;
        rnd_d   = '0;
      end
      default: begin
        state_d = IDLE;
        rnd_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rnd_q   <= '0;
      st_q    <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      st_q    <= st_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == ROUND) || (state_q == DONE);
  assign out_data  = st_q;
  assign rk_idx    = (state_q == ROUND) ? rnd_q : '0;
endmodule

// File: tb/tb_aes_round_seq.sv
// Bench for aes_round_seq: NR=10 and NR=14 instances against a byte-level AES model.

module tb_aes_round_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, in_valid, out_ready, sel;
  logic [127:0] in_data;
  logic [127:0] rk_tab [0:15];

  logic         ir10, ov10, bz10, ir14, ov14, bz14;
  logic [3:0]   ri10, ri14;
  logic [127:0] od10, od14, rkd10, rkd14;
  logic         iv10, iv14;

  assign iv10  = in_valid & ~sel;
  assign iv14  = in_valid & sel;
  assign rkd10 = rk_tab[ri10];
  assign rkd14 = rk_tab[ri14];

  aes_round_seq #(.NR(10), .RW(4)) u_dut10 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv10), .in_ready(ir10), .in_data(in_data),
    .rk_idx(ri10), .rk_data(rkd10), .out_valid(ov10), .out_ready(out_ready),
    .out_data(od10), .busy(bz10));

  aes_round_seq #(.NR(14), .RW(4)) u_dut14 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv14), .in_ready(ir14), .in_data(in_data),
    .rk_idx(ri14), .rk_data(rkd14), .out_valid(ov14), .out_ready(out_ready),
    .out_data(od14), .busy(bz14));

  logic         m_ir, m_ov, m_bz;
  logic [3:0]   m_ri;
  logic [127:0] m_od;
  assign m_ir = sel ? ir14 : ir10;
  assign m_ov = sel ? ov14 : ov10;
  assign m_bz = sel ? bz14 : bz10;
  assign m_ri = sel ? ri14 : ri10;
  assign m_od = sel ? od14 : od10;

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  logic [7:0] sb_t [0:255];

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse in GF(2^8), then the affine map.
  task automatic build_sbox;
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, b;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      sb_t[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sb_t[w[31:24]], sb_t[w[23:16]], sb_t[w[15:8]], sb_t[w[7:0]]};
  endfunction

  // Key words taken from the top of key; nk = 4 or 8.
  function automatic logic [127:0] round_key(input logic [255:0] key, input int nk, input int r);
    logic [31:0] w [0:63];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*r+4; i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) t = sub_word(t);
      w[i] = w[i-nk] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [255:0] key,
                                           input int nk, input int nr);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [127:0] k;
    k = round_key(key, nk, 0);
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ k[127-8*i -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sb_t[s[i]];
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++) t[4*c+w] = s[4*((c+w)%4)+w];
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++)
          s[4*c+w] = (r == nr) ? t[4*c+w] :
                     gmul(8'h02, t[4*c+w]) ^ gmul(8'h03, t[4*c+(w+1)%4]) ^
                     t[4*c+(w+2)%4] ^ t[4*c+(w+3)%4];
      k = round_key(key, nk, r);
      for (int i = 0; i < 16; i++) s[i] ^= k[127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) k[127-8*i -: 8] = s[i];
    return k;
  endfunction

  task automatic load_key(input logic [255:0] key, input int nk, input int nr);
    for (int r = 0; r < 16; r++) rk_tab[r] = (r <= nr) ? round_key(key, nk, r) : 128'h0;
  endtask

  // ---------------- block runner ----------------
  task automatic run_block(input string tag, input logic [127:0] pt, input int nr,
                           input bit noise, input int stall, output logic [127:0] ct);
    int lat;
    in_valid = 1'b1;
    in_data  = pt;
    chk({tag, " in_ready_idle"}, 128'(m_ir), 128'(1));
    tick;
    in_valid = 1'b0;
    lat = 1;
    while (!m_ov && lat <= nr + 5) begin
      chk({tag, " rk_idx"}, 128'(m_ri), 128'(lat));
      chk({tag, " in_ready_busy"}, 128'(m_ir), 128'(0));
      chk({tag, " busy"}, 128'(m_bz), 128'(1));
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = {$urandom, $urandom, $urandom, $urandom};
      end
      tick;
      lat++;
    end
    in_valid = 1'b0;
    chk({tag, " latency"}, 128'(lat), 128'(nr + 1));
    chk({tag, " out_valid"}, 128'(m_ov), 128'(1));
    ct = m_od;
    for (int s = 0; s < stall; s++) begin
      tick;
      chk({tag, " stall_valid"}, 128'(m_ov), 128'(1));
      chk({tag, " stall_data"}, m_od, ct);
      chk({tag, " stall_in_ready"}, 128'(m_ir), 128'(0));
    end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk({tag, " drain_in_ready"}, 128'(m_ir), 128'(1));
    chk({tag, " drain_out_valid"}, 128'(m_ov), 128'(0));
    chk({tag, " drain_busy"}, 128'(m_bz), 128'(0));
  endtask

  typedef struct {
    logic [255:0] key;
    int           nk;
    int           nr;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;

  vec_t vecs [4];

  localparam logic [255:0] K_C1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [127:0] P_C1 = 128'h00112233445566778899aabbccddeeff;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] ct, ct2;
    logic [255:0] key;
    int na, nv, cyc, n;
    int acc [2];
    int ovc [2];
    logic [127:0] ovd [2];

    vecs[0] = '{K_C1, 4, 10, P_C1, 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vecs[1] = '{{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4, 10,
                128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32};
    vecs[2] = '{256'h0, 4, 10, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
    vecs[3] = '{256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14,
                P_C1, 128'h8ea2b7ca516745bfeafc49904b496089};

    build_sbox();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sel = 1'b0; in_data = '0;
    load_key(K_C1, 4, 10);
    tick; tick;
    rst_n = 1'b1;
    chk("reset in_ready", 128'(m_ir), 128'(1));
    chk("reset out_valid", 128'(m_ov), 128'(0));
    chk("reset busy", 128'(m_bz), 128'(0));
    chk("reset rk_idx", 128'(m_ri), 128'(0));
    chk("reset out_data", m_od, 128'h0);

    // Known-answer table, both builds
    for (int i = 0; i < 4; i++) begin
      sel = (vecs[i].nr == 14);
      load_key(vecs[i].key, vecs[i].nk, vecs[i].nr);
      #1;
      run_block($sformatf("kat%0d", i), vecs[i].pt, vecs[i].nr, 1'b0, 0, ct);
      chk($sformatf("kat%0d ct", i), ct, vecs[i].ct);
    end

    // Back-pressure for 20 cycles, with in_valid/in_data noise during ROUND
    sel = 1'b0;
    load_key(K_C1, 4, 10);
    #1;
    run_block("stall20", P_C1, 10, 1'b1, 20, ct);
    chk("stall20 ct", ct, vecs[0].ct);

    // Back-to-back with in_valid held and out_ready tied high
    acc[0] = -1; acc[1] = -1; ovc[0] = -1; ovc[1] = -1; ovd[0] = '0; ovd[1] = '0;
    na = 0; nv = 0; cyc = 0;
    out_ready = 1'b1; in_valid = 1'b1; in_data = P_C1;
    while (nv < 2 && cyc < 80) begin
      if (m_ir && in_valid && na < 2) begin acc[na] = cyc; na++; end
      if (m_ov) begin ovc[nv] = cyc; ovd[nv] = m_od; nv++; end
      tick;
      cyc++;
      if (na == 1) in_data = 128'h0;
      if (na == 2) in_valid = 1'b0;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("b2b outputs_seen", 128'(nv), 128'(2));
    chk("b2b start_interval", 128'(acc[1] - acc[0]), 128'(12));
    chk("b2b accept_after_valid", 128'(acc[1]), 128'(ovc[0] + 1));
    chk("b2b ct0", ovd[0], aes_enc(P_C1, K_C1, 4, 10));
    chk("b2b ct1", ovd[1], aes_enc(128'h0, K_C1, 4, 10));

    // Reset while rnd == 5
    in_valid = 1'b1; in_data = P_C1;
    tick;
    in_valid = 1'b0;
    n = 0;
    while (m_ri != 4'd5 && n < 20) begin tick; n++; end
    chk("midrst reached_rnd5", 128'(m_ri), 128'(5));
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    chk("midrst in_ready", 128'(m_ir), 128'(1));
    chk("midrst out_valid", 128'(m_ov), 128'(0));
    chk("midrst busy", 128'(m_bz), 128'(0));
    chk("midrst rk_idx", 128'(m_ri), 128'(0));
    run_block("post_rst", P_C1, 10, 1'b0, 0, ct);
    chk("post_rst ct", ct, vecs[0].ct);

    // Random keys/plaintexts on both builds against the model
    for (int i = 0; i < 10; i++) begin
      int nr;
      sel = (i >= 7);
      nr  = sel ? 14 : 10;
      key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      load_key(key, sel ? 8 : 4, nr);
      ct2 = {$urandom, $urandom, $urandom, $urandom};
      #1;
      run_block($sformatf("rnd%0d", i), ct2, nr, 1'b1, $urandom_range(0, 4), ct);
      chk($sformatf("rnd%0d ct", i), ct, aes_enc(ct2, key, sel ? 8 : 4, nr));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
